instruction_fetch: RTL and testbench
====================================

# instruction_fetch

- Upstream stage of the control unit in the basic CPU.
- Holds the program counter and fetches instruction words from instruction memory over a req/ack handshake.
- Splits each word into a 5-bit opcode, driven onto the control unit's `address` input, and an 8-bit literal for the datapath muxes.
- Paces execution: exactly one opcode is presented per instruction, with a one-cycle `exec` strobe. A NOP opcode is presented at all other times, so the control unit never loads registers between instructions.

## Interface

Parameters:
- `PC_W`, 8 — program counter and instruction-memory address width.
- `LIT_W`, 8 — literal field width.
- `OP_W`, 5 — opcode width; matches the control unit address input.

Ports:
- `clk`  in  1  — single clock; all state updates on rising edge.
- `rst_n`  in  1  — asynchronous, active-low reset.
- `start`  in  1  — begin execution at PC 0; sampled only in IDLE or HALT.
- `imem_req`  out  1  — instruction read request.
- `imem_addr`  out  PC_W  — read address; equals the PC.
- `imem_ack`  in  1  — read data valid; sampled only while `imem_req`=1.
- `imem_data`  in  OP_W+LIT_W  — {opcode[12:8], literal[7:0]}.
- `address`  out  OP_W  — opcode to the control unit.
- `literal`  out  LIT_W  — immediate to the datapath.
- `exec`  out  1  — datapath register-load cycle strobe.
- `halted`  out  1  — a HALT opcode has been fetched.

## Operation

- Constants:
  - NOP_OP = 5'b11001 (undecoded by the control unit → no register loads).
  - HALT_OP = 5'b11111.
- FSM states: IDLE, FETCH, EXEC, HALT.
- Reset (async, any state, including mid-handshake):
  - state=IDLE, pc=0, `imem_req`=0, `address`=NOP_OP, `literal`=0, `exec`=0, `halted`=0.
  - An `imem_ack` arriving after reset is ignored.
- IDLE:
  - `start`=1 → FETCH, pc=0.
  - Otherwise stay.
- FETCH:
  - `imem_req`=1; `imem_addr`=pc, held stable until ack.
  - `imem_ack`=1 with opcode==HALT_OP → HALT, `halted`=1, `address` remains NOP_OP, pc not incremented.
  - `imem_ack`=1 with any other opcode → EXEC; register `address`=opcode, `literal`=imem_data[7:0], `exec`=1.
  - Opcodes 5'b11001–5'b11110 are passed through unchanged; they act as NOPs downstream.
- EXEC (exactly one cycle):
  - `exec`=1 and `address` valid; the datapath loads on the edge ending this cycle.
  - On exit: pc ← pc+1 modulo 2^PC_W (255 wraps to 0, execution continues), `address` ← NOP_OP, `exec` ← 0, → FETCH.
- HALT:
  - Outputs held: `halted`=1, `address`=NOP_OP.
  - `start`=1 → FETCH with pc=0, `halted` ← 0.
- `start` is ignored in FETCH and EXEC.
- `literal` holds its last value outside EXEC so mux inputs stay stable.

## Timing

- All outputs are registered, except `imem_addr`, which is the pc register.
- `start` sampled at edge k → `imem_req`=1 from cycle k+1.
- Zero-wait memory (ack in the first req cycle) → EXEC in the next cycle. Minimum throughput is 2 cycles per instruction.
- Each wait cycle without ack adds one cycle; `imem_req` and `imem_addr` stay constant during waits.
- `imem_req` drops in the same edge that accepts the ack. It re-asserts one cycle later, after EXEC, for pc+1.
- `exec` is high for exactly one cycle per non-HALT instruction, never back-to-back.

## Structure

- Shared package `cpu_defs` holds:
  - OP_W, LIT_W, PC_W.
  - NOP_OP, HALT_OP.
  - Instruction field bit positions.
  - FSM state encoding (2-bit: IDLE=0, FETCH=1, EXEC=2, HALT=3).
- One sub-module: `pc_counter`, a PC_W-bit register with synchronous clear and increment enable, plus async reset.
- The FSM and output registers live in `instruction_fetch`.

## Test plan

- Reset, then `start`; zero-wait memory with program {0x000A, 0x0105, 0x1F00}:
  - `address`=0,1 with `literal`=0x0A,0x05, each `exec` for 1 cycle, 2 cycles apart.
  - Then `halted`=1 and `address`=5'b11001.
- Memory ack delayed 3 cycles:
  - `imem_req` stays high 4 cycles with `imem_addr` constant; `exec` follows one cycle after ack.
- `rst_n` dropped during FETCH wait, late ack after release:
  - All outputs return to reset values immediately; the late ack is ignored and no `exec` occurs.
- `start` pulsed during EXEC and FETCH:
  - No change to pc or sequence.
  - `start` in HALT restarts at `imem_addr`=0 and `halted` clears.
- Program with no HALT, 256 instructions:
  - After pc=255, `imem_addr` wraps to 0; `exec` count equals instructions fetched.
- `imem_data`=0x1300 (opcode 5'b10011):
  - `address`=5'b10011 during the single `exec` cycle, and 5'b11001 before and after.

Source files
------------

// File: rtl/cpu_defs.sv
// rtl/cpu_defs.sv - shared widths, opcodes, field positions and fetch FSM encoding
//
// Purpose: constants shared by the instruction fetch stage and its sub-module.
// Ports: none (package).
package cpu_defs;

  localparam int OP_W    = 5;
  localparam int LIT_W   = 8;
  localparam int PC_W    = 8;
  localparam int INSTR_W = OP_W + LIT_W;

  // Instruction word layout: {opcode, literal}
  localparam int LIT_LSB = 0;
  localparam int LIT_MSB = LIT_LSB + LIT_W - 1;
  localparam int OP_LSB  = LIT_MSB + 1;
  localparam int OP_MSB  = OP_LSB + OP_W - 1;

  // NOP_OP is left undecoded by the control unit, so it loads no registers.
  localparam logic [OP_W-1:0] NOP_OP  = 5'b11001;
  localparam logic [OP_W-1:0] HALT_OP = 5'b11111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2,
    ST_HALT  = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/pc_counter.sv
// rtl/pc_counter.sv - program counter register with clear and increment
//
// Purpose: W-bit program counter; clear has priority over increment and
// increment wraps modulo 2^W.
// Ports:
//   clk   in  1  clock
//   rst_n in  1  asynchronous active-low reset (pc -> 0)
//   clr   in  1  synchronous clear to 0
//   inc   in  1  synchronous increment
//   pc    out W  current program counter
module pc_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] pc
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= '0;
    end else if (clr) begin
      pc <= '0;
    end else if (inc) begin
      pc <= pc + 1'b1;
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - program counter, instruction fetch and exec pacing
//
// Purpose: fetches instruction words over a req/ack handshake, presents one
// opcode per instruction with a single-cycle exec strobe, and NOP otherwise.
// Ports:
//   clk       in  1           clock
//   rst_n     in  1           asynchronous active-low reset
//   start     in  1           begin at pc 0 (honoured in IDLE/HALT only)
//   imem_req  out 1           instruction read request
//   imem_addr out PC_W        read address (the pc register)
//   imem_ack  in  1           read data valid
//   imem_data in  OP_W+LIT_W  {opcode, literal}
//   address   out OP_W        opcode to the control unit
//   literal   out LIT_W       immediate to the datapath
//   exec      out 1           datapath register-load strobe
//   halted    out 1           HALT opcode fetched
module instruction_fetch #(
  parameter int PC_W  = cpu_defs::PC_W,
  parameter int LIT_W = cpu_defs::LIT_W,
  parameter int OP_W  = cpu_defs::OP_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  imem_req,
  output logic [PC_W-1:0]       imem_addr,
  input  logic                  imem_ack,
  input  logic [OP_W+LIT_W-1:0] imem_data,
  output logic [OP_W-1:0]       address,
  output logic [LIT_W-1:0]      literal,
  output logic                  exec,
  output logic                  halted
);

  import cpu_defs::*;

  localparam logic [OP_W-1:0] NOP  = OP_W'(NOP_OP);
  localparam logic [OP_W-1:0] HALT = OP_W'(HALT_OP);

  fetch_state_t state, state_n;

  logic              req_n;
  logic [OP_W-1:0]   addr_n;
  logic [LIT_W-1:0]  lit_n;
  logic              exec_n;
  logic              halted_n;
  logic              pc_clr;
  logic              pc_inc;
  logic [OP_W-1:0]   op_field;
  logic [LIT_W-1:0]  lit_field;

  assign op_field  = imem_data[LIT_W +: OP_W];
  assign lit_field = imem_data[LIT_W-1:0];

  pc_counter #(
    .W (PC_W)
  ) u_pc (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (pc_clr),
    .inc   (pc_inc),
    .pc    (imem_addr)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      imem_req <= 1'b0;
      address  <= NOP;
      literal  <= '0;
      exec     <= 1'b0;
      halted   <= 1'b0;
    end else begin
      state    <= state_n;
      imem_req <= req_n;
      address  <= addr_n;
      literal  <= lit_n;
      exec     <= exec_n;
      halted   <= halted_n;
    end
  end

  // Outputs are registered, so each branch computes the value for the next
  // cycle. literal keeps its value unless a new instruction is accepted.
  always_comb begin
    state_n  = state;
    req_n    = imem_req;
    addr_n   = address;
    lit_n    = literal;
    exec_n   = 1'b0;
    halted_n = halted;
    pc_clr   = 1'b0;
    pc_inc   = 1'b0;

    unique case (state)
      ST_IDLE: begin
        if (start) begin
          state_n = ST_FETCH;
          pc_clr  = 1'b1;
          req_n   = 1'b1;
        end
      end

      ST_FETCH: begin
        if (imem_ack) begin
          req_n = 1'b0;
          if (op_field == HALT) begin
            // pc stays on the HALT word; address remains NOP.
            state_n  = ST_HALT;
            halted_n = 1'b1;
            addr_n   = NOP;
          end else begin
            state_n = ST_EXEC;
            addr_n  = op_field;
            lit_n   = lit_field;
            exec_n  = 1'b1;
          end
        end
      end

      ST_EXEC: begin
        // Datapath loads on this edge; request the next word right after.
        state_n = ST_FETCH;
        pc_inc  = 1'b1;
        addr_n  = NOP;
        req_n   = 1'b1;
      end

      ST_HALT: begin
        if (start) begin
          state_n  = ST_FETCH;
          pc_clr   = 1'b1;
          req_n    = 1'b1;
          halted_n = 1'b0;
        end
      end

      default: begin
        state_n = ST_IDLE;
        req_n   = 1'b0;
        addr_n  = NOP;
      end
    endcase
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// tb/tb_instruction_fetch.sv - directed self-checking bench for instruction_fetch
module tb_instruction_fetch;

  localparam logic [4:0] NOP_C = 5'b11001;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_ack;
  logic [12:0] imem_data;
  logic [4:0]  address;
  logic [7:0]  literal;
  logic        exec;
  logic        halted;

  logic [12:0] mem [256];
  int          mem_delay;
  int          wcnt;
  logic        mem_ack;
  logic [12:0] mem_data;
  logic        manual;
  logic        man_ack;
  logic [12:0] man_data;

  int total;
  int bad;
  int n_exec;
  int n_fetch;
  int exec_seen;
  int guard;
  int exp_pc;

  instruction_fetch dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .imem_req  (imem_req),
    .imem_addr (imem_addr),
    .imem_ack  (imem_ack),
    .imem_data (imem_data),
    .address   (address),
    .literal   (literal),
    .exec      (exec),
    .halted    (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign imem_ack  = manual ? man_ack  : mem_ack;
  assign imem_data = manual ? man_data : mem_data;

  // Memory responder: acks in the (mem_delay+1)-th cycle of a request.
  always @(negedge clk) begin
    if (imem_req) begin
      if (wcnt == mem_delay) begin
        mem_ack  = 1'b1;
        mem_data = mem[imem_addr];
      end else begin
        mem_ack = 1'b0;
      end
      wcnt = wcnt + 1;
    end else begin
      mem_ack = 1'b0;
      wcnt    = 0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_exec(input string tag);
    int i;
    i = 0;
    while (exec !== 1'b1 && i < 50) begin
      tick();
      i++;
    end
    chk(tag, 32'(exec), 32'd1);
  endtask

  task automatic wait_halted(input string tag);
    int i;
    i = 0;
    while (halted !== 1'b1 && i < 50) begin
      tick();
      i++;
    end
    chk(tag, 32'(halted), 32'd1);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    total = 0; bad = 0;
    rst_n = 1'b0; start = 1'b0;
    manual = 1'b0; man_ack = 1'b0; man_data = '0;
    mem_ack = 1'b0; mem_data = '0; wcnt = 0; mem_delay = 0;
    for (int i = 0; i < 256; i++) mem[i] = 13'h1F00;
    mem[0] = 13'h000A; mem[1] = 13'h0105; mem[2] = 13'h1F00;

    // Reset state
    tick(); tick();
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_addr", 32'(imem_addr), 32'd0);
    chk("rst_address", 32'(address), 32'(NOP_C));
    chk("rst_literal", 32'(literal), 32'd0);
    chk("rst_exec", 32'(exec), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    rst_n = 1'b1;
    tick();

    // Zero-wait program {0x000A, 0x0105, 0x1F00}
    pulse_start();
    chk("p1_req", 32'(imem_req), 32'd1);
    chk("p1_pc0", 32'(imem_addr), 32'd0);
    chk("p1_nop_before", 32'(address), 32'(NOP_C));
    tick();
    chk("p1_exec0", 32'(exec), 32'd1);
    chk("p1_op0", 32'(address), 32'd0);
    chk("p1_lit0", 32'(literal), 32'h0A);
    chk("p1_req_drop", 32'(imem_req), 32'd0);
    tick();
    chk("p1_exec_gap", 32'(exec), 32'd0);
    chk("p1_nop_gap", 32'(address), 32'(NOP_C));
    chk("p1_pc1", 32'(imem_addr), 32'd1);
    chk("p1_lit_hold", 32'(literal), 32'h0A);
    tick();
    chk("p1_exec1", 32'(exec), 32'd1);
    chk("p1_op1", 32'(address), 32'd1);
    chk("p1_lit1", 32'(literal), 32'h05);
    tick();
    chk("p1_pc2", 32'(imem_addr), 32'd2);
    tick();
    chk("p1_halted", 32'(halted), 32'd1);
    chk("p1_halt_nop", 32'(address), 32'(NOP_C));
    chk("p1_halt_req", 32'(imem_req), 32'd0);
    chk("p1_halt_pc", 32'(imem_addr), 32'd2);
    chk("p1_halt_exec", 32'(exec), 32'd0);

    // Restart from HALT with 3-cycle memory delay; start pulses in FETCH/EXEC
    mem[0] = 13'h0203; mem[1] = 13'h0407; mem[2] = 13'h1F00;
    mem_delay = 3;
    tick();
    pulse_start();
    chk("d_restart_pc", 32'(imem_addr), 32'd0);
    chk("d_halt_clr", 32'(halted), 32'd0);
    for (int i = 0; i < 3; i++) begin
      chk("d_wait_req", 32'(imem_req), 32'd1);
      chk("d_wait_addr", 32'(imem_addr), 32'd0);
      chk("d_wait_exec", 32'(exec), 32'd0);
      tick();
    end
    chk("d_req4", 32'(imem_req), 32'd1);
    chk("d_exec_early", 32'(exec), 32'd0);
    tick();
    chk("d_exec", 32'(exec), 32'd1);
    chk("d_op", 32'(address), 32'd2);
    chk("d_lit", 32'(literal), 32'h03);
    tick();
    chk("d_fetch_pc1", 32'(imem_addr), 32'd1);
    pulse_start();
    chk("s_fetch_pc", 32'(imem_addr), 32'd1);
    chk("s_fetch_req", 32'(imem_req), 32'd1);
    wait_exec("s_wait_exec");
    chk("s_op", 32'(address), 32'd4);
    pulse_start();
    chk("s_exec_pc", 32'(imem_addr), 32'd2);
    chk("s_exec_nop", 32'(address), 32'(NOP_C));
    wait_halted("s_wait_halt");
    chk("s_halt_pc", 32'(imem_addr), 32'd2);

    // Reset during FETCH wait, late ack afterwards
    manual = 1'b1; man_ack = 1'b0; man_data = 13'h0011;
    pulse_start();
    tick();
    chk("r_req_pre", 32'(imem_req), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("r_req", 32'(imem_req), 32'd0);
    chk("r_pc", 32'(imem_addr), 32'd0);
    chk("r_address", 32'(address), 32'(NOP_C));
    chk("r_literal", 32'(literal), 32'd0);
    chk("r_halted", 32'(halted), 32'd0);
    tick();
    rst_n = 1'b1;
    man_ack = 1'b1;
    exec_seen = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (exec === 1'b1 || imem_req === 1'b1) exec_seen++;
    end
    chk("r_late_ack_ignored", 32'(exec_seen), 32'd0);
    chk("r_late_address", 32'(address), 32'(NOP_C));
    man_ack = 1'b0;
    manual = 1'b0;

    // Opcode 5'b10011 passes through for one exec cycle only
    mem_delay = 0;
    mem[0] = 13'h1300; mem[1] = 13'h1F00;
    pulse_start();
    chk("o_nop_before", 32'(address), 32'(NOP_C));
    tick();
    chk("o_exec", 32'(exec), 32'd1);
    chk("o_op", 32'(address), 32'h13);
    tick();
    chk("o_nop_after", 32'(address), 32'(NOP_C));
    chk("o_exec_off", 32'(exec), 32'd0);
    wait_halted("o_halt");

    // 256-instruction program without HALT: pc wrap
    for (int i = 0; i < 256; i++) mem[i] = {5'(i % 25), 8'(i)};
    pulse_start();
    n_exec = 0; n_fetch = 0; guard = 0; exp_pc = 0;
    if (imem_req === 1'b1) n_fetch++;
    while (n_exec < 256 && guard < 2000) begin
      tick();
      guard++;
      if (imem_req === 1'b1) n_fetch++;
      if (exec === 1'b1) begin
        if (literal !== 8'(exp_pc) || address !== 5'(exp_pc % 25))
          chk("w_instr", {19'd0, address, literal}, {19'd0, 5'(exp_pc % 25), 8'(exp_pc)});
        n_exec++;
        exp_pc++;
      end
    end
    chk("w_exec_count", 32'(n_exec), 32'd256);
    chk("w_fetch_count", 32'(n_fetch), 32'(n_exec));
    tick();
    chk("w_wrap_addr", 32'(imem_addr), 32'd0);
    chk("w_wrap_req", 32'(imem_req), 32'd1);
    tick();
    chk("w_wrap_exec", 32'(exec), 32'd1);
    chk("w_wrap_op", 32'(address), 32'd0);
    chk("w_wrap_lit", 32'(literal), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
